aes_engine_datapath_ctrl: RTL

//  Engine-side responder to the AES HWPE controller FSM: consumes ctrl_engine start/clear/enable, returns engine flags.

---
 rtl/aes_engine_datapath_ctrl_if.sv | 39 +++
 rtl/aes_engine_datapath_ctrl.sv | 139 +++++++++++++
 2 files changed

// File: rtl/aes_engine_datapath_ctrl_if.sv
// Bundle of controller, stream and AES-core signals seen by the engine datapath.
// The engine side uses the slave modport; the controller/stream/core environment uses master.
interface aes_engine_datapath_ctrl_if #(
  parameter int DATA_W  = 32,
  parameter int BLOCK_W = 128,
  parameter int CNT_W   = 16
);
  logic               ctrl_clear_i;
  logic               ctrl_start_i;
  logic               ctrl_enable_i;
  logic [CNT_W-1:0]   nblocks_i;
  logic               in_valid_i;
  logic               in_ready_o;
  logic [DATA_W-1:0]  in_data_i;
  logic               out_valid_o;
  logic               out_ready_i;
  logic [DATA_W-1:0]  out_data_o;
  logic               core_start_o;
  logic [BLOCK_W-1:0] core_data_o;
  logic               core_done_i;
  logic [BLOCK_W-1:0] core_data_i;
  logic               flag_busy_o;
  logic               flag_done_o;
  logic [CNT_W-1:0]   flag_blk_o;

  modport slave (
    input  ctrl_clear_i, ctrl_start_i, ctrl_enable_i, nblocks_i,
    input  in_valid_i, in_data_i, out_ready_i, core_done_i, core_data_i,
    output in_ready_o, out_valid_o, out_data_o, core_start_o, core_data_o,
    output flag_busy_o, flag_done_o, flag_blk_o
  );

  modport master (
    output ctrl_clear_i, ctrl_start_i, ctrl_enable_i, nblocks_i,
    output in_valid_i, in_data_i, out_ready_i, core_done_i, core_data_i,
    input  in_ready_o, out_valid_o, out_data_o, core_start_o, core_data_o,
    input  flag_busy_o, flag_done_o, flag_blk_o
  );
endinterface

// File: rtl/aes_engine_datapath_ctrl.sv
// AES engine datapath: packs stream beats into a block, runs it through the core,
// and streams the result back out, repeating for a programmed number of blocks.
module aes_engine_datapath_ctrl #(
  parameter int DATA_W  = 32,
  parameter int BLOCK_W = 128,
  parameter int CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      reset_n,
  aes_engine_datapath_ctrl_if.slave bus
);

  localparam int BEATS  = BLOCK_W / DATA_W;
  localparam int BEAT_W = $clog2(BEATS);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CORE,
    ST_STORE,
    ST_DONE
  } state_e;

  state_e                       state_q, state_d;
  logic [BEAT_W-1:0]            beat_q, beat_d;
  logic [CNT_W-1:0]             blk_q, blk_d;
  logic [CNT_W-1:0]             nblk_q, nblk_d;
  logic                         core_first_q, core_first_d;
  logic [BEATS-1:0][DATA_W-1:0] in_blk_q, in_blk_d;
  logic [BEATS-1:0][DATA_W-1:0] out_blk_q, out_blk_d;

  logic             in_hs;
  logic             out_hs;
  logic [CNT_W-1:0] blk_inc;

  assign in_hs   = (state_q == ST_LOAD) && bus.ctrl_enable_i && bus.in_valid_i;
  assign out_hs  = (state_q == ST_STORE) && bus.out_ready_i;
  assign blk_inc = blk_q + CNT_W'(1);

  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    blk_d        = blk_q;
    nblk_d       = nblk_q;
    core_first_d = core_first_q;
    in_blk_d     = in_blk_q;
    out_blk_d    = out_blk_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.ctrl_start_i && bus.ctrl_enable_i) begin
          nblk_d  = (bus.nblocks_i == '0) ? CNT_W'(1) : bus.nblocks_i;
          beat_d  = '0;
          blk_d   = '0;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (in_hs) begin
          in_blk_d[beat_q] = bus.in_data_i;
          if (beat_q == LAST_BEAT) begin
            beat_d       = '0;
            core_first_d = 1'b1;
            state_d      = ST_CORE;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      // A done pulse in the very first CORE cycle is legal (zero-latency core).
      ST_CORE: begin
        core_first_d = 1'b0;
        if (bus.core_done_i) begin
          out_blk_d = bus.core_data_i;
          state_d   = ST_STORE;
        end
      end
      ST_STORE: begin
        if (out_hs) begin
          if (beat_q == LAST_BEAT) begin
            beat_d  = '0;
            blk_d   = blk_inc;
            state_d = (blk_inc < nblk_q) ? ST_LOAD : ST_DONE;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Clear discards any partial block and wins over a simultaneous start.
    if (bus.ctrl_clear_i) begin
      state_d      = ST_IDLE;
      beat_d       = '0;
      blk_d        = '0;
      nblk_d       = '0;
      core_first_d = 1'b0;
      in_blk_d     = '0;
      out_blk_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      beat_q       <= '0;
      blk_q        <= '0;
      nblk_q       <= '0;
      core_first_q <= 1'b0;
      in_blk_q     <= '0;
      out_blk_q    <= '0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      blk_q        <= blk_d;
      nblk_q       <= nblk_d;
      core_first_q <= core_first_d;
      in_blk_q     <= in_blk_d;
      out_blk_q    <= out_blk_d;
    end
  end

  assign bus.in_ready_o   = (state_q == ST_LOAD) && bus.ctrl_enable_i;
  assign bus.out_valid_o  = (state_q == ST_STORE);
  assign bus.out_data_o   = (state_q == ST_STORE) ? out_blk_q[beat_q] : '0;
  assign bus.core_start_o = (state_q == ST_CORE) && core_first_q;
  assign bus.core_data_o  = in_blk_q;
  assign bus.flag_busy_o  = (state_q != ST_IDLE);
  assign bus.flag_done_o  = (state_q == ST_DONE);
  assign bus.flag_blk_o   = blk_q;

endmodule
